// File: rtl/addr_alu_datapath.sv
// 65C02 datapath core: address generation, program counter, 8-bit ALU with
// decimal adjust, status register and branch-condition evaluation.
module addr_alu_datapath (
  input  logic        clk,
  input  logic        RST,
  input  logic [11:0] ab_op,
  input  logic [6:0]  alu_op,
  input  logic [9:0]  flag_op,
  input  logic        sync,
  input  logic        ld_m,
  input  logic        adj_m,
  input  logic        B,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
  output logic [15:0] AD,
  output logic [15:0] PC,
  output logic [7:0]  OUT,
  output logic        CO,
  output logic [7:0]  P,
  output logic        cond
);

  logic [7:0]  r_abl, r_abh, r_ahl, r_m;
  logic [15:0] r_pc;
  logic        r_n, r_v, r_d, r_i, r_z, r_c;
  logic [2:0]  r_csel;

  logic [7:0]  w_base, w_addend, w_adh;
  logic [8:0]  w_adl9;
  logic        w_aci;
  logic [3:0]  w_abh_op;

  assign w_abh_op = ab_op[8:5];

  // ADL base/addend mux; bit 8 of the sum is the carry into the high byte
  always_comb begin
    w_base = r_pc[7:0];
    case (ab_op[4:3])
      2'b00: w_base = r_pc[7:0];
      2'b01: w_base = r_abl;
      2'b10: w_base = DB;
      2'b11: w_base = r_ahl;
    endcase
    w_addend = 8'h00;
    case (ab_op[2:1])
      2'b00: w_addend = 8'h00;
      2'b01: w_addend = REG;
      2'b10: w_addend = DB;
      2'b11: w_addend = cond ? DB : 8'h00;
    endcase
  end

  assign w_adl9 = {1'b0, w_base} + {1'b0, w_addend} + {8'b0, ab_op[0]};
  assign w_aci  = w_adl9[8];

  always_comb begin
    w_adh = r_abh;
    case (w_abh_op)
      4'd0:    w_adh = r_pc[15:8];
      4'd1:    w_adh = r_pc[15:8] + {7'b0, w_aci};
      4'd2:    w_adh = r_pc[15:8] + {7'b0, w_aci} - 8'd1;
      4'd3:    w_adh = r_abh;
      4'd4:    w_adh = r_abh + {7'b0, w_aci};
      4'd5:    w_adh = DB;
      4'd6:    w_adh = DB + {7'b0, w_aci};
      4'd7:    w_adh = 8'h00;
      4'd8:    w_adh = 8'h01;
      4'd9:    w_adh = 8'hFF;
      default: w_adh = r_abh;
    endcase
  end

  assign AD = {w_adh, w_adl9[7:0]};
  assign PC = r_pc;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_abl <= 8'h00;
      r_abh <= 8'h00;
      r_ahl <= 8'h00;
      r_pc  <= 16'h0000;
      r_m   <= 8'h00;
    end else begin
      r_abl <= w_adl9[7:0];
      r_abh <= w_adh;
      if (ab_op[9]) r_ahl <= DB;
      r_pc  <= (ab_op[10] ? AD : r_pc) + {15'b0, ab_op[11]};
      if (ld_m) r_m <= DB;
    end
  end

  // ALU
  logic [3:0] w_fn;
  logic [7:0] w_rt, w_rb;
  logic       w_ci, w_hc, w_dec, w_dhi, w_vbin, w_valu;
  logic [8:0] w_sum9, w_dadd1;
  logic [4:0] w_lo5;
  logic [3:0] w_dsub_lo, w_dsub_hi;

  assign w_fn = alu_op[3:0];
  assign w_rt = alu_op[4] ? r_m : DB;
  assign w_rb = (w_fn == 4'd4) ? ~w_rt : w_rt;

  always_comb begin
    case (alu_op[6:5])
      2'b01:   w_ci = 1'b0;
      2'b10:   w_ci = 1'b1;
      default: w_ci = r_c;
    endcase
  end

  assign w_sum9 = {1'b0, REG} + {1'b0, w_rb} + {8'b0, w_ci};
  assign w_lo5  = {1'b0, REG[3:0]} + {1'b0, w_rb[3:0]} + {4'b0, w_ci};
  assign w_hc   = w_lo5[4];
  assign w_vbin = (REG[7] == w_rb[7]) && (w_sum9[7] != REG[7]);
  assign w_dec  = adj_m && r_d;

  // BCD add: low fix-up first, then the high test sees its carry
  assign w_dadd1 = w_sum9 + (((w_sum9[3:0] > 4'd9) || w_hc) ? 9'd6 : 9'd0);
  assign w_dhi   = (w_dadd1[8:4] > 5'd9) || w_sum9[8];
  // BCD subtract: a clear carry out of a nibble means that nibble borrowed
  assign w_dsub_lo = w_hc      ? w_sum9[3:0] : w_sum9[3:0] - 4'd6;
  assign w_dsub_hi = w_sum9[8] ? w_sum9[7:4] : w_sum9[7:4] - 4'd6;

  always_comb begin
    OUT    = REG;
    CO     = 1'b0;
    w_valu = 1'b0;
    case (w_fn)
      4'd0: OUT = REG | w_rt;
      4'd1: OUT = REG & w_rt;
      4'd2: OUT = REG ^ w_rt;
      4'd3: begin
        w_valu = w_vbin;
        if (w_dec) begin
          OUT = w_dhi ? (w_dadd1[7:0] + 8'h60) : w_dadd1[7:0];
          CO  = w_dhi;
        end else begin
          OUT = w_sum9[7:0];
          CO  = w_sum9[8];
        end
      end
      4'd4: begin
        w_valu = w_vbin;
        CO     = w_sum9[8];
        OUT    = w_dec ? {w_dsub_hi, w_dsub_lo} : w_sum9[7:0];
      end
      4'd5: begin
        OUT = {REG[6:0], w_ci};
        CO  = REG[7];
      end
      4'd6: begin
        OUT = {w_ci, REG[7:1]};
        CO  = REG[0];
      end
      4'd7:  OUT = REG;
      4'd8:  OUT = w_rt;
      4'd9:  OUT = REG + 8'd1;
      4'd10: OUT = REG - 8'd1;
      4'd11: OUT = REG & w_rt;
      default: OUT = REG;
    endcase
  end

  // Status register; a non-hold V field overrides the BIT-style V load
  always_ff @(posedge clk) begin
    if (RST) begin
      r_n    <= 1'b0;
      r_v    <= 1'b0;
      r_d    <= 1'b0;
      r_i    <= 1'b1;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_csel <= 3'b000;
    end else if (sync) begin
      r_csel <= DB[7:5];
      if (flag_op[9:8] == 2'b11) begin
        r_n <= DB[7];
        r_v <= DB[6];
        r_d <= DB[3];
        r_i <= DB[2];
        r_z <= DB[1];
        r_c <= DB[0];
      end else begin
        case (flag_op[1:0])
          2'b01:   r_c <= CO;
          2'b10:   r_c <= 1'b0;
          2'b11:   r_c <= 1'b1;
          default: ;
        endcase
        case (flag_op[3:2])
          2'b01: begin
            r_n <= OUT[7];
            r_z <= (OUT == 8'h00);
          end
          2'b10: begin
            r_n <= DB[7];
            r_v <= DB[6];
            r_z <= (OUT == 8'h00);
          end
          default: ;
        endcase
        case (flag_op[5:4])
          2'b01:   r_v <= w_valu;
          2'b10:   r_v <= 1'b0;
          2'b11:   r_v <= DB[6];
          default: ;
        endcase
        case (flag_op[7:6])
          2'b01:   r_i <= 1'b0;
          2'b10:   r_i <= 1'b1;
          default: ;
        endcase
        case (flag_op[9:8])
          2'b01:   r_d <= 1'b0;
          2'b10:   r_d <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign P = {r_n, r_v, 1'b1, B, r_d, r_i, r_z, r_c};

  logic w_cflag;
  always_comb begin
    case (r_csel[2:1])
      2'b00:   w_cflag = r_n;
      2'b01:   w_cflag = r_v;
      2'b10:   w_cflag = r_c;
      default: w_cflag = r_z;
    endcase
  end

  assign cond = (w_cflag == r_csel[0]);

endmodule

// File: tb/tb_addr_alu_datapath.sv
// Directed-vector bench for addr_alu_datapath with hand-computed expectations.
module tb_addr_alu_datapath;

  logic        clk = 1'b0;
  logic        RST;
  logic [11:0] ab_op;
  logic [6:0]  alu_op;
  logic [9:0]  flag_op;
  logic        sync, ld_m, adj_m, B;
  logic [7:0]  DB, REG;
  logic [15:0] AD, PC;
  logic [7:0]  OUT, P;
  logic        CO, cond;

  int n_chk = 0;
  int n_err = 0;

  addr_alu_datapath dut (
    .clk(clk), .RST(RST), .ab_op(ab_op), .alu_op(alu_op), .flag_op(flag_op),
    .sync(sync), .ld_m(ld_m), .adj_m(adj_m), .B(B), .DB(DB), .REG(REG),
    .AD(AD), .PC(PC), .OUT(OUT), .CO(CO), .P(P), .cond(cond)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST = 1'b1; ab_op = '0; alu_op = '0; flag_op = '0;
    sync = 1'b0; ld_m = 1'b0; adj_m = 1'b0; B = 1'b0; DB = '0; REG = '0;
    tick();
    chk("rst_pc", PC, 16'h0000);
    chk("rst_p", {8'h00, P}, 16'h0024);
    chk("rst_cond", {15'b0, cond}, 16'h0001);
    RST = 1'b0;

    // PC increment
    ab_op = 12'h800;
    for (int i = 0; i < 3; i++) begin
      #1 chk("inc_ad", AD, 16'(i));
      tick();
    end
    chk("inc_pc", PC, 16'h0003);

    // jump via AHL low byte + DB high byte
    ab_op = 12'h200; DB = 8'h34; tick();
    ab_op = 12'h4B8; DB = 8'h12;
    #1 chk("jmp_ad", AD, 16'h1234);
    tick();
    chk("jmp_pc", PC, 16'h1234);

    // indexed: AHL=F0 + REG=20 carries into DB+ci
    ab_op = 12'h200; DB = 8'hF0; tick();
    ab_op = 12'h0DA; DB = 8'h12; REG = 8'h20;
    #1 chk("idx_ad", AD, 16'h1310);
    tick();
    ab_op = 12'h068;
    #1 chk("abx_hold", AD, 16'h1310);
    ab_op = 12'h0BA;
    #1 chk("nocarry_ad", AD, 16'h1210);
    ab_op = 12'h13A;
    #1 chk("ff_ad", AD, 16'hFF10);

    // PC wrap with simultaneous ld_pc and inc_pc
    ab_op = 12'h200; DB = 8'hFF; tick();
    ab_op = 12'hD38;
    #1 chk("wrap_ad", AD, 16'hFFFF);
    tick();
    chk("wrap_pc", PC, 16'h0000);
    ab_op = 12'h000;

    // binary ADC with flag update
    alu_op = 7'h23; REG = 8'h7F; DB = 8'h01; flag_op = 10'h015; sync = 1'b1;
    #1 chk("adc_out", {8'h00, OUT}, 16'h0080);
    chk("adc_co", {15'b0, CO}, 16'h0000);
    tick();
    sync = 1'b0; flag_op = '0;
    chk("adc_p", {8'h00, P}, 16'h00E4);
    chk("adc_cond", {15'b0, cond}, 16'h0000);

    // set D, then decimal arithmetic
    flag_op = 10'h200; sync = 1'b1; DB = 8'h00; tick();
    sync = 1'b0; flag_op = '0;
    chk("sed_p", {8'h00, P}, 16'h00EC);
    adj_m = 1'b1; REG = 8'h19; DB = 8'h28;
    #1 chk("dadc_out", {8'h00, OUT}, 16'h0047);
    chk("dadc_co", {15'b0, CO}, 16'h0000);
    REG = 8'h99; DB = 8'h01;
    #1 chk("dadc99_out", {8'h00, OUT}, 16'h0000);
    chk("dadc99_co", {15'b0, CO}, 16'h0001);
    alu_op = 7'h44; REG = 8'h50; DB = 8'h01;
    #1 chk("dsbc_out", {8'h00, OUT}, 16'h0049);
    chk("dsbc_co", {15'b0, CO}, 16'h0001);
    adj_m = 1'b0; alu_op = 7'h23; REG = 8'h19; DB = 8'h28;
    #1 chk("noadj_out", {8'h00, OUT}, 16'h0041);

    // M operand, shifts, decrement
    ld_m = 1'b1; DB = 8'h0F; tick();
    ld_m = 1'b0;
    alu_op = 7'h11; REG = 8'h3C; DB = 8'hFF;
    #1 chk("andm_out", {8'h00, OUT}, 16'h000C);
    chk("andm_co", {15'b0, CO}, 16'h0000);
    alu_op = 7'h45; REG = 8'h81;
    #1 chk("asl_out", {7'h00, CO, OUT}, 16'h0103);
    alu_op = 7'h26;
    #1 chk("lsr_out", {7'h00, CO, OUT}, 16'h0140);
    alu_op = 7'h0A; REG = 8'h00;
    #1 chk("dec_out", {7'h00, CO, OUT}, 16'h00FF);

    // load-all wins over concurrent field writes
    alu_op = 7'h07; REG = 8'h55; flag_op = 10'h3E6; DB = 8'hC7; sync = 1'b1;
    tick();
    sync = 1'b0; flag_op = '0;
    chk("ldall_p", {8'h00, P}, 16'h00E7);
    chk("ldall_cond", {15'b0, cond}, 16'h0000);
    B = 1'b1;
    #1 chk("b_p", {8'h00, P}, 16'h00F7);
    B = 1'b0;

    // branch condition select
    sync = 1'b1; DB = 8'hD0; tick();
    sync = 1'b0;
    chk("bne_cond", {15'b0, cond}, 16'h0000);
    sync = 1'b1; DB = 8'hF0; tick();
    sync = 1'b0;
    chk("beq_cond", {15'b0, cond}, 16'h0001);

    // backward branch from 1210
    ab_op = 12'h200; DB = 8'h10; tick();
    ab_op = 12'h4B8; DB = 8'h12; tick();
    chk("br_pc", PC, 16'h1210);
    ab_op = 12'h046; DB = 8'hF0;
    #1 chk("br_back_ad", AD, 16'h1200);
    ab_op = 12'h026;
    #1 chk("br_fwd_ad", AD, 16'h1300);

    // reset overrides pending ops
    ab_op = 12'hC26; flag_op = 10'h3FF; sync = 1'b1; RST = 1'b1; tick();
    RST = 1'b0; sync = 1'b0; flag_op = '0; ab_op = 12'h068;
    #1 chk("rst2_ad", AD, 16'h0000);
    chk("rst2_pc", PC, 16'h0000);
    chk("rst2_p", {8'h00, P}, 16'h0024);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
